// File: rtl/run_ctrl_if.sv
// Button inputs and counter-drive outputs of the run control stage.
interface run_ctrl_if;
  logic i_btn_ss;
  logic i_btn_clr;
  logic i_btn_step;
  logic o_enable;
  logic o_clr_n;
  logic o_running;

  modport master (
    output i_btn_ss, i_btn_clr, i_btn_step,
    input  o_enable, o_clr_n, o_running
  );

  modport slave (
    input  i_btn_ss, i_btn_clr, i_btn_step,
    output o_enable, o_clr_n, o_running
  );
endinterface

// File: rtl/run_ctrl.sv
// Counter front end: button sync/debounce, IDLE/RUN/PAUSE control and a
// prescaler producing the count enable pulse train and the counter clear.
//
// state   | meaning
// S_IDLE  | stopped, prescaler forced to 0, no enable
// S_RUN   | prescaler counting, enable on every wrap
// S_PAUSE | prescaler held, step presses give single enables
module run_ctrl #(
  parameter int DIV    = 50000,
  parameter int DB_CYC = 16
) (
  input logic       i_clk,
  input logic       i_areset,
  run_ctrl_if.slave bus
);

  function automatic int clogb2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) <= v) r = i + 1;
    return r;
  endfunction

  localparam int PW = clogb2(DIV - 1);
  localparam int DW = clogb2(DB_CYC);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  // bit 0: start/stop, bit 1: clear, bit 2: step
  logic [2:0]    w_raw;
  logic [2:0]    r_meta, r_sync, r_deb, r_deb_d, r_press;
  logic [DW-1:0] r_db_cnt [3];

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          r_enable, w_enable_nxt;
  logic          r_clr_n, r_clr_pend, r_running;
  logic          w_ss_p, w_clr_p, w_step_p, w_wrap;

  assign w_raw    = {bus.i_btn_step, bus.i_btn_clr, bus.i_btn_ss};
  assign w_ss_p   = r_press[0];
  assign w_clr_p  = r_press[1];
  assign w_step_p = r_press[2];

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_meta  <= w_raw;
      r_sync  <= r_meta;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          r_deb[i]    <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_enable   <= 1'b0;
      r_clr_n    <= 1'b0;
      r_clr_pend <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre      <= w_pre_nxt;
      r_enable   <= w_enable_nxt;
      r_clr_n    <= ~(w_clr_p | r_clr_pend);
      r_clr_pend <= w_clr_p;
      r_running  <= (r_state == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pre_nxt    = r_pre;
    w_wrap       = (r_state == S_RUN) && (r_pre == PRE_MAX);
    w_enable_nxt = 1'b0;

    if (w_clr_p) begin
      w_state_nxt = S_IDLE;
    end else if (w_ss_p) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_PAUSE;
        S_PAUSE: w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    case (r_state)
      S_RUN:   w_pre_nxt = w_wrap ? '0 : r_pre + PW'(1);
      S_PAUSE: w_pre_nxt = r_pre;
      default: w_pre_nxt = '0;
    endcase

    // A clear press or an open clear window suppresses any pending pulse.
    if (!w_clr_p && !r_clr_pend)
      w_enable_nxt = w_wrap || ((r_state == S_PAUSE) && w_step_p);
  end

  assign bus.o_enable  = r_enable;
  assign bus.o_clr_n   = r_clr_n;
  assign bus.o_running = r_running;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with DIV=4, DB_CYC=3; expected cycles hand-computed.
module tb_run_ctrl;

  logic clk;
  logic areset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   en_cnt;
  int   en_dbl;
  logic en_prev;

  run_ctrl_if u_if ();

  run_ctrl #(.DIV(4), .DB_CYC(3)) u_dut (
    .i_clk    (clk),
    .i_areset (areset),
    .bus      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    en_cnt  = 0;
    en_dbl  = 0;
    en_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (u_if.o_enable === 1'b1) begin
      en_cnt++;
      if (en_prev) en_dbl++;
    end
    en_prev = (u_if.o_enable === 1'b1);
  end

  task automatic at_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    areset  = 1'b0;
    u_if.i_btn_ss   = 1'b0;
    u_if.i_btn_clr  = 1'b0;
    u_if.i_btn_step = 1'b0;

    // reset values and release
    at_cyc(3);
    chk("rst_enable",  int'(u_if.o_enable),  0);
    chk("rst_running", int'(u_if.o_running), 0);
    chk("rst_clr_n",   int'(u_if.o_clr_n),   0);
    areset = 1'b1;
    #1;
    chk("rel_clr_n_before_edge", int'(u_if.o_clr_n), 0);
    at_cyc(4);
    chk("rel_clr_n_after_edge", int'(u_if.o_clr_n),   1);
    chk("rel_running",          int'(u_if.o_running), 0);
    chk("rel_enable",           int'(u_if.o_enable),  0);

    // start: press pulse at 17, RUN at 18, running at 19, enables 22,26,...
    at_cyc(10); u_if.i_btn_ss = 1'b1;
    at_cyc(18); chk("start_running_lat", int'(u_if.o_running), 0);
    at_cyc(19); chk("start_running",     int'(u_if.o_running), 1);
    at_cyc(20); u_if.i_btn_ss = 1'b0;
    at_cyc(21); chk("first_en_early", int'(u_if.o_enable), 0);
    at_cyc(22); chk("first_en",       int'(u_if.o_enable), 1);
    at_cyc(23); chk("first_en_width", int'(u_if.o_enable), 0);

    // 2-cycle glitch on start/stop is filtered
    at_cyc(40); u_if.i_btn_ss = 1'b1;
    at_cyc(42); u_if.i_btn_ss = 1'b0;
    at_cyc(60);
    chk("glitch_running", int'(u_if.o_running), 1);
    chk("run_en_count",   en_cnt, 10);

    // pause: press pulse 67, PAUSE at 68, running low at 69
    u_if.i_btn_ss = 1'b1;
    at_cyc(68); chk("pause_running_lat", int'(u_if.o_running), 1);
    at_cyc(69); chk("pause_running",     int'(u_if.o_running), 0);
    at_cyc(70); u_if.i_btn_ss = 1'b0;
    at_cyc(90); chk("pause_en_count", en_cnt, 12);

    // three steps in PAUSE: enables at 98, 113, 128
    u_if.i_btn_step = 1'b1;
    at_cyc(96);  u_if.i_btn_step = 1'b0;
    at_cyc(98);  chk("step1_en",       int'(u_if.o_enable), 1);
    at_cyc(99);  chk("step1_en_width", int'(u_if.o_enable), 0);
    at_cyc(105); u_if.i_btn_step = 1'b1;
    at_cyc(111); u_if.i_btn_step = 1'b0;
    at_cyc(113); chk("step2_en", int'(u_if.o_enable), 1);
    at_cyc(120); u_if.i_btn_step = 1'b1;
    at_cyc(126); u_if.i_btn_step = 1'b0;
    at_cyc(140);
    chk("step_en_count", en_cnt, 15);
    chk("step_running",  int'(u_if.o_running), 0);

    // resume: RUN at 148 with prescaler held at 2, next enable at 150
    u_if.i_btn_ss = 1'b1;
    at_cyc(149); chk("resume_running",  int'(u_if.o_running), 1);
                 chk("resume_en_early", int'(u_if.o_enable),  0);
    at_cyc(150); chk("resume_en_phase", int'(u_if.o_enable),  1);
                 u_if.i_btn_ss = 1'b0;
    at_cyc(154); chk("resume_en_next",  int'(u_if.o_enable),  1);

    // step in RUN is ignored
    at_cyc(160); u_if.i_btn_step = 1'b1;
    at_cyc(166); u_if.i_btn_step = 1'b0;
    at_cyc(180); chk("run_step_en_count", en_cnt, 23);

    // clear + start/stop together, press at 189 coincides with a wrap
    at_cyc(182); u_if.i_btn_clr = 1'b1; u_if.i_btn_ss = 1'b1;
    at_cyc(189); chk("clr_pre_clr_n",  int'(u_if.o_clr_n),   1);
    at_cyc(190); chk("clr_clr_n_0",    int'(u_if.o_clr_n),   0);
                 chk("clr_wrap_supp",  int'(u_if.o_enable),  0);
    at_cyc(191); chk("clr_clr_n_1",    int'(u_if.o_clr_n),   0);
                 chk("clr_running",    int'(u_if.o_running), 0);
    at_cyc(192); chk("clr_clr_n_end",  int'(u_if.o_clr_n),   1);
                 u_if.i_btn_clr = 1'b0; u_if.i_btn_ss = 1'b0;
    at_cyc(210); chk("clr_en_count", en_cnt, 25);

    // restart from IDLE: prescaler from 0, enable at 222
    u_if.i_btn_ss = 1'b1;
    at_cyc(219); chk("restart_running", int'(u_if.o_running), 1);
    at_cyc(220); u_if.i_btn_ss = 1'b0;
    at_cyc(221); chk("restart_en_early", int'(u_if.o_enable), 0);
    at_cyc(222); chk("restart_en",       int'(u_if.o_enable), 1);

    // reset inside a clear window
    at_cyc(230); u_if.i_btn_clr = 1'b1;
    at_cyc(238); chk("clr2_clr_n", int'(u_if.o_clr_n),  0);
                 chk("clr2_supp",  int'(u_if.o_enable), 0);
    areset = 1'b0;
    #1;
    chk("rst_clr_enable",  int'(u_if.o_enable),  0);
    chk("rst_clr_running", int'(u_if.o_running), 0);
    chk("rst_clr_clr_n",   int'(u_if.o_clr_n),   0);
    at_cyc(239); u_if.i_btn_clr = 1'b0;
    at_cyc(241); areset = 1'b1;
    at_cyc(242); chk("rst_clr_rel_clr_n", int'(u_if.o_clr_n), 1);

    // reset in the middle of a debounce count
    at_cyc(250); u_if.i_btn_ss = 1'b1;
    at_cyc(254); areset = 1'b0; u_if.i_btn_ss = 1'b0;
    #1;
    chk("rst_db_enable",  int'(u_if.o_enable),  0);
    chk("rst_db_running", int'(u_if.o_running), 0);
    chk("rst_db_clr_n",   int'(u_if.o_clr_n),   0);
    at_cyc(257); areset = 1'b1;
    at_cyc(290);
    chk("post_rst_running", int'(u_if.o_running), 0);
    chk("post_rst_clr_n",   int'(u_if.o_clr_n),   1);
    chk("final_en_count",   en_cnt, 29);
    chk("en_width_viol",    en_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Front-end control stage for the mod-M counter chain: turns raw start/stop, clear and step buttons into a registered `enable` pulse train and a registered active-low clear, which drive the counter's `enable` and `areset` inputs directly. It contains the button synchronisers and debouncers, a three-state IDLE/RUN/PAUSE machine and a programmable prescaler that sets the count rate.

## Interface
- `DIV`, default 50000: prescaler ratio; one `enable` pulse every `DIV` clocks in RUN; legal range ≥ 2.
- `DB_CYC`, default 16: debounce length in clocks; legal range ≥ 1.
- Internal widths: prescaler `clogb2(DIV-1)` bits, debounce counters `clogb2(DB_CYC)` bits.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `areset`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous.
- `btn_step`  in  1  raw single-step button, active-high, asynchronous.
- `enable`  out  1  registered one-cycle count pulse to the counter.
- `clr_n`  out  1  registered active-low clear to the counter's `areset`.
- `running`  out  1  high while the state machine is in RUN.

## Operation
- Reset (`areset` = 0): state IDLE, prescaler 0, debounced levels 0, synchronisers 0.
  - Outputs during reset: `enable` = 0, `running` = 0, `clr_n` = 0.
  - `clr_n` rises to 1 on the first `clk` edge after `areset` releases.
- Input path, per button:
  - Two-flop synchroniser.
  - Debouncer: the counter clears when the synchronised level equals the debounced level. Otherwise it increments, and the debounced level takes the new value on the edge where the count reaches `DB_CYC`; the counter clears on that edge.
  - Press pulse: registered, one cycle, on the rising edge of the debounced level. Falling edges produce nothing.
- State machine:
  - IDLE: `ss` press → RUN.
  - RUN: `ss` press → PAUSE.
  - PAUSE: `ss` press → RUN.
  - `clr` press in any state → IDLE. Clear has priority over `ss` and `step` in the same cycle.
- Prescaler:
  - RUN: counts 0..`DIV`-1 and wraps. `enable` = 1 for the single cycle after the cycle in which state is RUN and the prescaler equals `DIV`-1.
  - PAUSE: held, so phase is preserved across pause/resume.
  - IDLE: forced to 0.
- Step:
  - In PAUSE, a `step` press gives `enable` = 1 on the next cycle; the prescaler is unchanged.
  - `step` presses in IDLE or RUN are ignored.
- Clear:
  - A `clr` press drives `clr_n` = 0 for exactly 2 cycles, starting the cycle after the press.
  - `enable` is forced to 0 during those 2 cycles and at all times in IDLE.
- `running` is registered and equals (state == RUN).

## Timing
- Button latency: the press pulse is high in the cycle that starts `DB_CYC`+3 edges after the first edge that samples the raw input high. This assumes the raw input stays stable.
- Glitches shorter than `DB_CYC` synchronised cycles produce no press.
- State changes take effect on the edge after the press pulse; `running` follows one edge later.
- RUN entered from IDLE: the prescaler starts at 0 in the first RUN cycle. The first `enable` comes `DIV` cycles later, then every `DIV` cycles after that.
- `ss` press in the same cycle the prescaler sits at `DIV`-1 while in RUN: that wrap's `enable` is still issued, then the machine enters PAUSE.
- `clr` press in the same cycle as a pending wrap: the wrap's `enable` is suppressed.
- Reset asserted mid-operation (including mid-clear or mid-debounce): all state returns to reset values immediately, with no pending pulse.

## Test plan
- `DIV`=4, `DB_CYC`=3; reset, then release → `clr_n` 0 during reset and 1 one edge after release; `enable` and `running` stay 0.
- `btn_ss` high for 10 cycles → `running` = 1. `enable` then pulses every 4 cycles, the first 4 cycles after RUN entry. Each pulse is 1 cycle wide.
- In RUN, pulse `btn_ss` high for 2 cycles (glitch) → no state change. Hold it 10 cycles → PAUSE, no further `enable`. Press again → RUN, and the phase continues (the next `enable` keeps the pre-pause spacing).
- In PAUSE, press `btn_step` three times → exactly 3 single-cycle `enable` pulses and no state change. In RUN, `step` → no extra pulse.
- In RUN, press `btn_clr` and `btn_ss` simultaneously → state IDLE, `clr_n` low for exactly 2 cycles, `enable` stays 0, and the prescaler restarts from 0 on the next RUN.
- Assert `areset` during a clear's low `clr_n` window and during an active debounce count → all outputs are at reset values. After release there is no spurious press or `enable`.
